pipe_ctrl: RTL and testbench

Pipeline control unit. It produces the 2-bit hold/flush codes that drive every `DFF_SET`-style pipeline register (PC, IF/ID, ID/EX), plus the fetch redirect for jumps and interrupts. It arbitrates between jump, load-use hazard, multi-cycle divide stall and external interrupt, and holds interrupt-return state (EPC, in-interrupt flag). It sits beside the pipeline and feeds the `hold_flag_i` of each stage register directly.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_ctrl_div_timer.sv | 30 +++
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared hold/flush codes and controller state encoding for the pipeline
// control unit and the stage registers it drives.
package pipe_ctrl_pkg;

  localparam logic [1:0] HOLD_RUN   = 2'b00;
  localparam logic [1:0] HOLD_FLUSH = 2'b01;
  localparam logic [1:0] HOLD_STALL = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN,
    ST_DIV_WAIT
  } state_t;

endpackage

// File: rtl/pipe_ctrl_div_timer.sv
// Divide stall timer: loads the divide latency, counts down, and flags the
// final stall-free cycle when the count reaches one.
module pipe_ctrl_div_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          last
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: arbitrates jump, divide stall, load-use hazard and
// interrupt entry into per-stage hold/flush codes and a fetch redirect.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          DW      = 32,
  parameter int          DIV_LAT = 34,
  parameter logic [DW-1:0] IRQ_VEC = DW'(32'h0000_0100)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_i,
  input  logic [DW-1:0] jump_addr_i,
  input  logic          load_use_i,
  input  logic          div_start_i,
  input  logic          ex_valid_i,
  input  logic [DW-1:0] ex_pc_i,
  input  logic          irq_req_i,
  input  logic          irq_en_i,
  input  logic          mret_i,
  output logic [1:0]    hold_pc_o,
  output logic [1:0]    hold_if_id_o,
  output logic [1:0]    hold_id_ex_o,
  output logic          jump_o,
  output logic [DW-1:0] jump_addr_o,
  output logic          div_done_o,
  output logic          irq_ack_o,
  output logic          in_irq_o,
  output logic [DW-1:0] epc_o,
  output logic          busy_o
);

  localparam int CW = $clog2(DIV_LAT + 1);

  state_t        state, state_nxt;
  logic          in_irq;
  logic [DW-1:0] epc;
  logic          tmr_load, tmr_dec, tmr_last;
  logic          irq_take, in_irq_clr;

  pipe_ctrl_div_timer #(.CW(CW)) u_div_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (CW'(DIV_LAT)),
    .dec      (tmr_dec),
    .last     (tmr_last)
  );

  always_comb begin
    state_nxt    = state;
    hold_pc_o    = HOLD_RUN;
    hold_if_id_o = HOLD_RUN;
    hold_id_ex_o = HOLD_RUN;
    jump_o       = 1'b0;
    jump_addr_o  = '0;
    div_done_o   = 1'b0;
    irq_ack_o    = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    irq_take     = 1'b0;
    in_irq_clr   = 1'b0;
    if (rst) begin
      hold_pc_o    = HOLD_FLUSH;
      hold_if_id_o = HOLD_FLUSH;
      hold_id_ex_o = HOLD_FLUSH;
    end else begin
      case (state)
        ST_RUN: begin
          if (jump_i) begin
            jump_o       = 1'b1;
            jump_addr_o  = jump_addr_i;
            hold_if_id_o = HOLD_FLUSH;
            hold_id_ex_o = HOLD_FLUSH;
            in_irq_clr   = mret_i;
          end else if (div_start_i) begin
            hold_pc_o    = HOLD_STALL;
            hold_if_id_o = HOLD_STALL;
            hold_id_ex_o = HOLD_STALL;
            tmr_load     = 1'b1;
            state_nxt    = ST_DIV_WAIT;
          end else if (load_use_i) begin
            hold_pc_o    = HOLD_STALL;
            hold_if_id_o = HOLD_STALL;
            hold_id_ex_o = HOLD_FLUSH;
          end else if (irq_req_i && irq_en_i && !in_irq && ex_valid_i) begin
            // EX instruction retires; the handler returns to the one after it.
            jump_o       = 1'b1;
            jump_addr_o  = IRQ_VEC;
            hold_if_id_o = HOLD_FLUSH;
            hold_id_ex_o = HOLD_FLUSH;
            irq_ack_o    = 1'b1;
            irq_take     = 1'b1;
          end
        end
        ST_DIV_WAIT: begin
          if (tmr_last) begin
            div_done_o = 1'b1;
            state_nxt  = ST_RUN;
          end else begin
            hold_pc_o    = HOLD_STALL;
            hold_if_id_o = HOLD_STALL;
            hold_id_ex_o = HOLD_STALL;
            tmr_dec      = 1'b1;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      in_irq <= 1'b0;
      epc    <= '0;
    end else begin
      state <= state_nxt;
      if (in_irq_clr) begin
        in_irq <= 1'b0;
      end else if (irq_take) begin
        in_irq <= 1'b1;
        epc    <= ex_pc_i + DW'(4);
      end
    end
  end

  assign in_irq_o = in_irq;
  assign epc_o    = epc;
  assign busy_o   = (state == ST_DIV_WAIT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a DIV_LAT=4 instance checked throughout and a
// DIV_LAT=1 instance, sharing inputs, checked for the short-divide case.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        load_use_i;
  logic        div_start_i;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        irq_req_i;
  logic        irq_en_i;
  logic        mret_i;

  logic [1:0]  hold_pc, hold_if_id, hold_id_ex;
  logic        jump_o, div_done, irq_ack, in_irq, busy;
  logic [31:0] jump_addr_o, epc;

  logic [1:0]  hold_pc_1, hold_if_id_1, hold_id_ex_1;
  logic        jump_o_1, div_done_1, irq_ack_1, in_irq_1, busy_1;
  logic [31:0] jump_addr_o_1, epc_1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DW(32), .DIV_LAT(4), .IRQ_VEC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .load_use_i(load_use_i), .div_start_i(div_start_i), .ex_valid_i(ex_valid_i),
    .ex_pc_i(ex_pc_i), .irq_req_i(irq_req_i), .irq_en_i(irq_en_i), .mret_i(mret_i),
    .hold_pc_o(hold_pc), .hold_if_id_o(hold_if_id), .hold_id_ex_o(hold_id_ex),
    .jump_o(jump_o), .jump_addr_o(jump_addr_o), .div_done_o(div_done),
    .irq_ack_o(irq_ack), .in_irq_o(in_irq), .epc_o(epc), .busy_o(busy)
  );

  pipe_ctrl #(.DW(32), .DIV_LAT(1), .IRQ_VEC(32'h0000_0100)) dut1 (
    .clk(clk), .rst(rst), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .load_use_i(load_use_i), .div_start_i(div_start_i), .ex_valid_i(ex_valid_i),
    .ex_pc_i(ex_pc_i), .irq_req_i(irq_req_i), .irq_en_i(irq_en_i), .mret_i(mret_i),
    .hold_pc_o(hold_pc_1), .hold_if_id_o(hold_if_id_1), .hold_id_ex_o(hold_id_ex_1),
    .jump_o(jump_o_1), .jump_addr_o(jump_addr_o_1), .div_done_o(div_done_1),
    .irq_ack_o(irq_ack_1), .in_irq_o(in_irq_1), .epc_o(epc_1), .busy_o(busy_1)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled at
  // the falling edge, mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    jump_i = 0; jump_addr_i = 0; load_use_i = 0; div_start_i = 0;
    ex_valid_i = 0; ex_pc_i = 0; irq_req_i = 0; irq_en_i = 0; mret_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; jump_i = 1; jump_addr_i = 32'h44; div_start_i = 1;
    sample();
    vectors++;
    if ({hold_pc, hold_if_id, hold_id_ex} !== 6'b01_01_01) begin
      $display("FAIL reset_codes got=%b want=010101", {hold_pc, hold_if_id, hold_id_ex});
      miscompares++;
    end
    vectors++;
    if ({jump_o, div_done, irq_ack} !== 3'b000) begin
      $display("FAIL reset_pulses got=%b want=000", {jump_o, div_done, irq_ack});
      miscompares++;
    end
    tick();
    tick();
    idle_inputs();
    rst = 0;
    sample();
    vectors++;
    if ({busy, in_irq, epc} !== {2'b00, 32'h0}) begin
      $display("FAIL reset_state got busy=%b in_irq=%b epc=%h want 0/0/0", busy, in_irq, epc);
      miscompares++;
    end
    vectors++;
    if ({hold_pc, hold_if_id, hold_id_ex} !== 6'b00_00_00) begin
      $display("FAIL post_reset_codes got=%b want=000000", {hold_pc, hold_if_id, hold_id_ex});
      miscompares++;
    end
    tick();
  endtask

  task automatic test_jump();
    jump_i = 1; jump_addr_i = 32'h80;
    sample();
    vectors++;
    if ({jump_o, jump_addr_o} !== {1'b1, 32'h80}) begin
      $display("FAIL jump_redirect got jump=%b addr=%h want 1/00000080", jump_o, jump_addr_o);
      miscompares++;
    end
    vectors++;
    if ({hold_pc, hold_if_id, hold_id_ex} !== 6'b00_01_01) begin
      $display("FAIL jump_codes got=%b want=000101", {hold_pc, hold_if_id, hold_id_ex});
      miscompares++;
    end
    tick();
    jump_i = 0;
    sample();
    vectors++;
    if ({jump_o, jump_addr_o, hold_pc, hold_if_id, hold_id_ex} !== {1'b0, 32'h0, 6'b0}) begin
      $display("FAIL jump_after got jump=%b addr=%h codes=%b want 0/0/000000",
               jump_o, jump_addr_o, {hold_pc, hold_if_id, hold_id_ex});
      miscompares++;
    end
    tick();
  endtask

  task automatic test_load_use();
    load_use_i = 1;
    sample();
    vectors++;
    if ({hold_pc, hold_if_id, hold_id_ex, jump_o} !== 7'b10_10_01_0) begin
      $display("FAIL load_use_codes got=%b want=1010010", {hold_pc, hold_if_id, hold_id_ex, jump_o});
      miscompares++;
    end
    tick();
    load_use_i = 0;
    sample();
    vectors++;
    if ({hold_pc, hold_if_id, hold_id_ex} !== 6'b00_00_00) begin
      $display("FAIL load_use_after got=%b want=000000", {hold_pc, hold_if_id, hold_id_ex});
      miscompares++;
    end
    tick();
  endtask

  task automatic test_divide();
    // cycle t
    div_start_i = 1;
    sample();
    vectors++;
    if ({hold_pc, hold_if_id, hold_id_ex, busy} !== 7'b10_10_10_0) begin
      $display("FAIL div_t got codes/busy=%b want=1010100", {hold_pc, hold_if_id, hold_id_ex, busy});
      miscompares++;
    end
    tick();
    div_start_i = 0;
    // t+1..t+3 stall, jump at t+2 ignored; short instance finishes at t+1
    for (int k = 1; k <= 3; k++) begin
      jump_i = (k == 2); jump_addr_i = (k == 2) ? 32'h400 : 32'h0;
      sample();
      vectors++;
      if ({hold_pc, hold_if_id, hold_id_ex, busy, div_done, jump_o} !== 9'b10_10_10_1_0_0) begin
        $display("FAIL div_stall_t%0d got codes/busy/done/jump=%b want=101010100",
                 k, {hold_pc, hold_if_id, hold_id_ex, busy, div_done, jump_o});
        miscompares++;
      end
      if (k == 1) begin
        vectors++;
        if ({div_done_1, busy_1, hold_pc_1, hold_if_id_1, hold_id_ex_1} !== 8'b1_1_000000) begin
          $display("FAIL div_lat1_done got done/busy/codes=%b want=11000000",
                   {div_done_1, busy_1, hold_pc_1, hold_if_id_1, hold_id_ex_1});
          miscompares++;
        end
      end
      tick();
    end
    jump_i = 0; jump_addr_i = 0;
    // t+4
    sample();
    vectors++;
    if ({div_done, busy, hold_pc, hold_if_id, hold_id_ex} !== 8'b1_1_000000) begin
      $display("FAIL div_done_t4 got done/busy/codes=%b want=11000000",
               {div_done, busy, hold_pc, hold_if_id, hold_id_ex});
      miscompares++;
    end
    tick();
    sample();
    vectors++;
    if ({div_done, busy} !== 2'b00) begin
      $display("FAIL div_after got done/busy=%b want=00", {div_done, busy});
      miscompares++;
    end
    tick();
  endtask

  task automatic test_irq();
    irq_en_i = 1; ex_valid_i = 1; ex_pc_i = 32'hFFFF_FFFC; irq_req_i = 1;
    sample();
    vectors++;
    if ({irq_ack, jump_o, jump_addr_o} !== {2'b11, 32'h100}) begin
      $display("FAIL irq_take got ack=%b jump=%b addr=%h want 1/1/00000100", irq_ack, jump_o, jump_addr_o);
      miscompares++;
    end
    vectors++;
    if ({hold_pc, hold_if_id, hold_id_ex} !== 6'b00_01_01) begin
      $display("FAIL irq_codes got=%b want=000101", {hold_pc, hold_if_id, hold_id_ex});
      miscompares++;
    end
    tick();
    sample();
    vectors++;
    if ({epc, in_irq, irq_ack, jump_o} !== {32'h0, 3'b100}) begin
      $display("FAIL irq_wrap got epc=%h in_irq=%b ack=%b jump=%b want 0/1/0/0", epc, in_irq, irq_ack, jump_o);
      miscompares++;
    end
    tick();
    jump_i = 1; mret_i = 1; jump_addr_i = 32'h40; ex_pc_i = 32'h200;
    sample();
    vectors++;
    if ({jump_o, jump_addr_o, irq_ack} !== {1'b1, 32'h40, 1'b0}) begin
      $display("FAIL mret_jump got jump=%b addr=%h ack=%b want 1/00000040/0", jump_o, jump_addr_o, irq_ack);
      miscompares++;
    end
    tick();
    jump_i = 0; mret_i = 0; jump_addr_i = 0;
    sample();
    vectors++;
    if ({in_irq, irq_ack, jump_addr_o} !== {2'b01, 32'h100}) begin
      $display("FAIL irq_retake got in_irq=%b ack=%b addr=%h want 0/1/00000100", in_irq, irq_ack, jump_addr_o);
      miscompares++;
    end
    tick();
    irq_req_i = 0;
    sample();
    vectors++;
    if ({epc, in_irq} !== {32'h204, 1'b1}) begin
      $display("FAIL irq_epc got epc=%h in_irq=%b want 00000204/1", epc, in_irq);
      miscompares++;
    end
    jump_i = 1; mret_i = 1;
    tick();
    jump_i = 0; mret_i = 0;
    tick();
  endtask

  task automatic test_simultaneous();
    jump_i = 1; jump_addr_i = 32'h1234; div_start_i = 1; load_use_i = 1;
    irq_req_i = 1; irq_en_i = 1; ex_valid_i = 1; ex_pc_i = 32'h500;
    sample();
    vectors++;
    if ({jump_o, jump_addr_o, irq_ack, hold_pc, hold_if_id, hold_id_ex} !== {1'b1, 32'h1234, 7'b0_000101}) begin
      $display("FAIL simul_jump got jump=%b addr=%h ack=%b codes=%b want 1/00001234/0/000101",
               jump_o, jump_addr_o, irq_ack, {hold_pc, hold_if_id, hold_id_ex});
      miscompares++;
    end
    tick();
    jump_i = 0; jump_addr_i = 0; div_start_i = 0; load_use_i = 0; ex_valid_i = 0;
    sample();
    vectors++;
    if ({busy, irq_ack, jump_o, hold_pc, hold_if_id, hold_id_ex} !== 9'b0) begin
      $display("FAIL simul_defer got busy/ack/jump/codes=%b want=000000000",
               {busy, irq_ack, jump_o, hold_pc, hold_if_id, hold_id_ex});
      miscompares++;
    end
    tick();
    ex_valid_i = 1;
    sample();
    vectors++;
    if ({irq_ack, jump_addr_o} !== {1'b1, 32'h100}) begin
      $display("FAIL simul_irq_later got ack=%b addr=%h want 1/00000100", irq_ack, jump_addr_o);
      miscompares++;
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_div();
    div_start_i = 1;
    tick();
    div_start_i = 0;
    tick();
    rst = 1;
    sample();
    vectors++;
    if ({hold_pc, hold_if_id, hold_id_ex, div_done} !== 7'b01_01_01_0) begin
      $display("FAIL rst_mid_div got codes/done=%b want=0101010", {hold_pc, hold_if_id, hold_id_ex, div_done});
      miscompares++;
    end
    tick();
    rst = 0;
    sample();
    vectors++;
    if ({busy, in_irq, epc} !== {2'b00, 32'h0}) begin
      $display("FAIL rst_mid_div_state got busy=%b in_irq=%b epc=%h want 0/0/0", busy, in_irq, epc);
      miscompares++;
    end
    for (int k = 0; k < 6; k++) begin
      sample();
      vectors++;
      if ({div_done, busy} !== 2'b00) begin
        $display("FAIL rst_mid_div_nodone cyc%0d got done/busy=%b want=00", k, {div_done, busy});
        miscompares++;
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    test_reset();
    test_jump();
    test_load_use();
    test_divide();
    test_irq();
    test_simultaneous();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
